// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NUM_REQ valid/ready requesters, responses tagged by id
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_op_b,
  input  logic [NUM_REQ*2-1:0]       req_op_code,
  output logic [WIDTH-1:0]           alu_op_a,
  output logic [WIDTH-1:0]           alu_op_b,
  output logic [1:0]                 alu_op_code,
  input  logic [WIDTH-1:0]           alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       busy,
  output logic [15:0]                op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [1:0]        op_code_q, op_code_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d, cur_id_q, cur_id_d, last_grant_q, last_grant_d, gnt_id;
  logic [15:0]       op_count_q, op_count_d;
  logic              gnt_found;
  // Scan downward so the nearest valid requester after last_grant wins
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_id = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end
  assign req_ready = (state_q == IDLE && gnt_found) ? NUM_REQ'(1) << gnt_id : '0;
  always_comb begin
    state_d = state_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    op_code_d = op_code_q;
    result_d = result_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    cur_id_d = cur_id_q;
    last_grant_d = last_grant_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: if (gnt_found) begin
        op_a_d = req_op_a[int'(gnt_id)*WIDTH +: WIDTH];
        op_b_d = req_op_b[int'(gnt_id)*WIDTH +: WIDTH];
        op_code_d = req_op_code[int'(gnt_id)*2 +: 2];
        cur_id_d = gnt_id;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_result;
        rsp_id_d = cur_id_q;
        rsp_valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        last_grant_d = cur_id_q;
        op_count_d = op_count_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_a_q <= '0;
      op_b_q <= '0;
      op_code_q <= '0;
      result_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      cur_id_q <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      op_code_q <= op_code_d;
      result_q <= result_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      cur_id_q <= cur_id_d;
      last_grant_q <= last_grant_d;
      op_count_q <= op_count_d;
    end
  end
  assign alu_op_a = op_a_q;
  assign alu_op_b = op_b_q;
  assign alu_op_code = op_code_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = result_q;
  assign busy = state_q != IDLE;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of grant order, latency, backpressure, async reset and op_count wrap
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_op_a = '0;
  logic [31:0] req_op_b = '0;
  logic [7:0]  req_op_code = '0;
  logic [7:0]  alu_op_a, alu_op_b, alu_result, rsp_result;
  logic [1:0]  alu_op_code, rsp_id;
  logic        rsp_valid, busy;
  logic        rsp_ready = 1'b0;
  logic [15:0] op_count;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  exp_res [4] = '{8'd42, 8'd99, 8'h30, 8'h55};
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  alu_arbiter #(.WIDTH(8), .NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_code(req_op_code),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy), .op_count(op_count)
  );

  // Reference ALU: add, sub, and, xor
  assign alu_result = alu_op_code == 2'd0 ? alu_op_a + alu_op_b :
                      alu_op_code == 2'd1 ? alu_op_a - alu_op_b :
                      alu_op_code == 2'd2 ? alu_op_a & alu_op_b : alu_op_a ^ alu_op_b;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    req_op_a    = {8'hAA, 8'hF0, 8'd100, 8'd12};
    req_op_b    = {8'hFF, 8'h3C, 8'd1, 8'd30};
    req_op_code = 8'b11_10_01_00;
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op_a", alu_op_a, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    reset = 1'b1;
    tick();
    // single request from requester 0, operands changed after grant
    req_valid = 4'b0001;
    #1;
    chk("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    req_op_a[7:0] = 8'd99;
    chk("t1_busy", busy, 1);
    chk("t1_alu_a", alu_op_a, 12);
    chk("t1_alu_b", alu_op_b, 30);
    chk("t1_exec_rsp_valid", rsp_valid, 0);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_result", rsp_result, 42);
    rsp_ready = 1'b1;
    tick();
    chk("t1_op_count", op_count, 1);
    chk("t1_idle", busy, 0);
    req_op_a[7:0] = 8'd12;
    // all four valid from fresh reset: order 0,1,2,3,0
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_grant%0d", i), req_ready, 4'b0001 << exp_order[i]);
      tick();
      chk($sformatf("t2_exec_ready%0d", i), req_ready, 0);
      tick();
      chk($sformatf("t2_rsp_id%0d", i), rsp_id, exp_order[i]);
      chk($sformatf("t2_rsp_res%0d", i), rsp_result, exp_res[exp_order[i]]);
      tick();
    end
    req_valid = 4'b0000;
    chk("t2_op_count", op_count, 5);
    // backpressure on requester 2
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("t3_grant", req_ready, 4'b0100);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_valid%0d", i), rsp_valid, 1);
      chk($sformatf("t3_id%0d", i), rsp_id, 2);
      chk($sformatf("t3_res%0d", i), rsp_result, 8'h30);
      chk($sformatf("t3_ready%0d", i), req_ready, 0);
      chk($sformatf("t3_busy%0d", i), busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_rsp_drop", rsp_valid, 0);
    chk("t3_op_count", op_count, 6);
    // rotation: last grant 2, requesters 1 and 3 valid
    req_valid = 4'b1010;
    #1;
    chk("t4_first", req_ready, 4'b1000);
    tick();
    tick();
    chk("t4_id_first", rsp_id, 3);
    tick();
    #1;
    chk("t4_second", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t4_id_second", rsp_id, 1);
    chk("t4_res_second", rsp_result, 99);
    tick();
    chk("t4_op_count", op_count, 8);
    // async reset while in RESP
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t5_pre_valid", rsp_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_op_count", op_count, 0);
    chk("t5_busy", busy, 0);
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("t5_priority", req_ready, 4'b0001);
    req_valid = 4'b0000;
    // op_count wrap via preload
    tick();
    force dut.op_count_q = 16'hFFFF;
    tick();
    release dut.op_count_q;
    #1;
    chk("t6_preload", op_count, 16'hFFFF);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t6_res", rsp_result, 99);
    tick();
    chk("t6_wrap", op_count, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single ALU datapath (op_a, op_b, 2-bit op_code, combinational result) among NUM_REQ requesters.
- Each requester presents operands and an op_code under a valid/ready handshake.
- The arbiter grants in round-robin order, drives the ALU from registered operands, captures the result, and returns it tagged with the requester index.
- Sits between the requesting engines and the ALU instance, replacing the free-running op_code sequencer when requester-driven operation is needed.

Parameters:
WIDTH, 8, operand/result width in bits
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  requester i has an operation pending
req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
req_op_a  input  NUM_REQ*WIDTH  operand A; slice i = bits [i*WIDTH +: WIDTH]
req_op_b  input  NUM_REQ*WIDTH  operand B, same packing
req_op_code  input  NUM_REQ*2  op code, slice i = bits [i*2 +: 2]
alu_op_a  output  WIDTH  to ALU op_a (registered)
alu_op_b  output  WIDTH  to ALU op_b (registered)
alu_op_code  output  2  to ALU op_code (registered)
alu_result  input  WIDTH  from ALU result (combinational from alu_op_*)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  ID_W  index of requester that issued the operation
rsp_result  output  WIDTH  captured ALU result
busy  output  1  high whenever state != IDLE
op_count  output  16  completed operations, wraps 0xFFFF->0x0000

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; alu_op_a/b=0; alu_op_code=0; rsp_valid=0; rsp_id=0; rsp_result=0; op_count=0; last_grant=NUM_REQ-1, so requester 0 has first priority. Outputs hold reset values while reset=0.
- State IDLE:
  - req_ready is combinational. It is the one-hot bit of the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready is all-zero if no req_valid is set, and all-zero in every state other than IDLE.
  - On grant g: latch the slices of g into alu_op_a/b/code; store g as cur_id; go to EXEC.
- State EXEC (1 cycle):
  - alu_op_* are stable; the ALU settles.
  - At the clock edge: rsp_result<=alu_result, rsp_id<=cur_id, rsp_valid<=1; go to RESP.
- State RESP:
  - Hold rsp_valid, rsp_id and rsp_result stable until rsp_ready=1.
  - On handshake: rsp_valid<=0; last_grant<=cur_id; op_count<=op_count+1; go to IDLE.
  - alu_op_* keep their last values; they are not cleared.
- Latency: grant cycle -> rsp_valid asserted 2 clocks later. Minimum initiation interval is 3 cycles, with rsp_ready held high.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ grants.
- Requesters may deassert req_valid before being granted; no grant is issued to a non-valid requester.
- Operand slices are sampled only in the grant cycle; later changes have no effect.
- Simultaneous valids in IDLE: only one grant. The others wait; their requests are not lost, since they keep valid asserted.
- rsp_ready asserted outside RESP is ignored.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded, rsp_valid drops immediately, and op_count is cleared.
- Width rules: rsp_result is exactly WIDTH bits from the ALU with no extension. op_count wraps modulo 2^16.

Test Plan:
1. Reset then single request: req_valid=4'b0001, op_a=8'd12, op_b=8'd30, op_code=2'b00. Required: req_ready=0001 in the grant cycle, rsp_valid high 2 cycles later, rsp_id=0, rsp_result equal to the ALU output for 12,30,op 0, op_count=1.
2. All four valid continuously with rsp_ready=1. Required grant order 0,1,2,3,0 at 3-cycle spacing, and rsp_id sequence 0,1,2,3,0.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_valid/id/result stable; req_ready=0 throughout; busy=1; after rsp_ready=1, IDLE on the next cycle.
4. Priority rotation: last grant was 2, and requesters 1 and 3 are valid. Required: grant 3 first, then 1.
5. Async reset asserted during RESP with rsp_valid=1. Required: rsp_valid=0 and op_count=0 before the next clk edge; after release, requester 0 has priority.
6. op_count wrap: force 0xFFFF completions (or preload via a bench shortcut), then complete one more. Required: op_count=0x0000.
